// File: rtl/ins_pkg.sv
// Shared constants and types for the instruction dispatch front end.
package ins_pkg;

    localparam int INS_W   = 64;
    localparam int OP_W    = 4;
    localparam int OP_LSB  = 60;
    localparam int BUF_BIT = 59;

    typedef enum logic [OP_W-1:0] {
        OP_CONF = 4'd0,
        OP_LOAD = 4'd1,
        OP_CALC = 4'd2,
        OP_SAVE = 4'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE
    } disp_state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_SAVE;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Show-ahead instruction FIFO with a registered full flag.
module ins_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_one
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             r_full;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_cnt == '0);
    assign o_one   = (r_cnt == {{AW{1'b0}}, 1'b1});

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == FULL_CNT);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ins_dispatch.sv
// In-order instruction issue to conf/load/calc/save units with per-buffer hazard counters.
module ins_dispatch
    import ins_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PEND_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [INS_W-1:0] ins,
    output logic             conf_valid,
    output logic             load_valid,
    output logic             calc_valid,
    output logic             save_valid,
    input  logic             conf_ready,
    input  logic             load_ready,
    input  logic             calc_ready,
    input  logic             save_ready,
    output logic [INS_W-1:0] unit_ins,
    input  logic [1:0]       load_done,
    input  logic [1:0]       calc_done,
    input  logic [1:0]       save_done,
    output logic             working,
    output logic             ins_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    disp_state_t             r_state;
    disp_state_t             w_state_nxt;
    logic [INS_W-1:0]        w_head;
    logic [INS_W-1:0]        r_ins;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_one;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_take;
    logic                    w_err_set;
    logic                    w_legal;
    logic                    w_clear;
    logic                    w_hs;
    logic                    w_in_issue;
    logic [OP_W-1:0]         w_head_op;
    logic [OP_W-1:0]         w_iss_op;
    logic                    w_head_b;
    logic                    w_iss_b;
    logic [1:0][PEND_W-1:0]  r_load_pend;
    logic [1:0][PEND_W-1:0]  r_calc_pend;
    logic [1:0][PEND_W-1:0]  r_save_pend;
    logic                    r_err;
    logic                    r_working;

    assign w_push    = ins_valid && !w_full;
    assign ins_ready = !w_full;

    ins_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INS_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (ins),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_one   (w_one)
    );

    assign w_head_op = w_head[OP_LSB +: OP_W];
    assign w_head_b  = w_head[BUF_BIT];
    assign w_legal   = op_legal(w_head_op);

    always_comb begin
        w_clear = 1'b0;
        case (w_head_op)
            OP_CONF: w_clear = (r_load_pend == '0) && (r_calc_pend == '0) && (r_save_pend == '0);
            OP_LOAD: w_clear = (r_calc_pend[w_head_b] == '0) && (r_load_pend[w_head_b] != PEND_MAX);
            OP_CALC: w_clear = (r_load_pend[w_head_b] == '0) && (r_save_pend[w_head_b] == '0)
                               && (r_calc_pend[w_head_b] != PEND_MAX);
            OP_SAVE: w_clear = (r_calc_pend[w_head_b] == '0) && (r_save_pend[w_head_b] != PEND_MAX);
            default: w_clear = 1'b0;
        endcase
    end

    assign w_iss_op   = r_ins[OP_LSB +: OP_W];
    assign w_iss_b    = r_ins[BUF_BIT];
    assign w_in_issue = (r_state == ST_ISSUE);
    assign conf_valid = w_in_issue && (w_iss_op == OP_CONF);
    assign load_valid = w_in_issue && (w_iss_op == OP_LOAD);
    assign calc_valid = w_in_issue && (w_iss_op == OP_CALC);
    assign save_valid = w_in_issue && (w_iss_op == OP_SAVE);
    assign w_hs       = (conf_valid && conf_ready) || (load_valid && load_ready)
                     || (calc_valid && calc_ready) || (save_valid && save_ready);
    assign unit_ins   = r_ins;
    assign ins_err    = r_err;
    assign working    = r_working;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_take      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty)
                    w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_empty) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_legal) begin
                    w_pop     = 1'b1;
                    w_err_set = 1'b1;
                    if (w_one && !w_push)
                        w_state_nxt = ST_IDLE;
                end else if (w_clear) begin
                    w_pop       = 1'b1;
                    w_take      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A push landing this cycle makes the FIFO non-empty next cycle.
                if (w_hs)
                    w_state_nxt = (w_empty && !w_push) ? ST_IDLE : ST_CHECK;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Issue and done together cancel; a done against an empty counter is ignored.
    function automatic logic [PEND_W-1:0] pend_nxt(input logic [PEND_W-1:0] cnt,
                                                   input logic inc, input logic done);
        if (inc && done)
            return cnt;
        if (inc)
            return cnt + 1'b1;
        if (done && (cnt != '0))
            return cnt - 1'b1;
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ins       <= '0;
            r_err       <= 1'b0;
            r_working   <= 1'b0;
            r_load_pend <= '0;
            r_calc_pend <= '0;
            r_save_pend <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take)
                r_ins <= w_head;
            if (w_err_set)
                r_err <= 1'b1;
            r_working <= !w_empty || w_in_issue || (r_load_pend != '0)
                         || (r_calc_pend != '0) || (r_save_pend != '0);
            for (int b = 0; b < 2; b++) begin
                r_load_pend[b] <= pend_nxt(r_load_pend[b],
                    w_hs && (w_iss_op == OP_LOAD) && (w_iss_b == 1'(b)), load_done[b]);
                r_calc_pend[b] <= pend_nxt(r_calc_pend[b],
                    w_hs && (w_iss_op == OP_CALC) && (w_iss_b == 1'(b)), calc_done[b]);
                r_save_pend[b] <= pend_nxt(r_save_pend[b],
                    w_hs && (w_iss_op == OP_SAVE) && (w_iss_b == 1'(b)), save_done[b]);
            end
        end
    end

endmodule

// File: doc/ins_dispatch.md
# ins_dispatch

Instruction front end of `fpga_top`. It accepts 64-bit host instructions over a valid/ready channel and buffers them in a small FIFO. It checks each head instruction against per-buffer hazards, then issues it in order to the configuration, load, calculation or save unit. It also drives the top-level `working` status.

## Interface
- `FIFO_DEPTH`, 4: instruction FIFO entries; power of two, minimum 2.
- `PEND_W`, 3: width of each outstanding-operation counter; counters saturate at 2^PEND_W-1.
- `clk` input 1: core clock; every register is clocked on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ins_valid` input 1: host instruction valid.
- `ins_ready` output 1: FIFO not full.
- `ins` input 64: instruction word.
- `conf_valid`/`load_valid`/`calc_valid`/`save_valid` output 1 each: issue strobe, one per unit.
- `conf_ready`/`load_ready`/`calc_ready`/`save_ready` input 1 each: the unit accepts the instruction.
- `unit_ins` output 64: the issued instruction word, shared by all four units.
- `load_done`/`calc_done`/`save_done` input 2 each: one-cycle completion pulse, one bit per buffer index.
- `working` output 1: the FIFO is non-empty, an instruction is being issued, or any counter is non-zero.
- `ins_err` output 1: sticky; set when an illegal opcode is seen.

## Operation
- Field layout:
  - `ins[63:60]` is the opcode: CONF=0, LOAD=1, CALC=2, SAVE=3, anything else illegal.
  - `ins[59]` is the buffer index `b` for LOAD, CALC and SAVE.
  - All remaining bits are opaque and are passed through unchanged.
- Counters: `load_pend[b]`, `calc_pend[b]` and `save_pend[b]`, one set per buffer.
  - A counter increments on the issue handshake for its opcode and buffer.
  - It decrements on the matching `*_done[b]` pulse.
  - A simultaneous issue and done leave the counter unchanged.
  - A done pulse while the counter is 0 is ignored.
- Hazard rules for the head instruction; it issues only when the rule holds:
  - CONF: all six counters are 0 (full drain).
  - LOAD b: `calc_pend[b]`==0 and `load_pend[b]` is not saturated.
  - CALC b: `load_pend[b]`==0, `save_pend[b]`==0, and `calc_pend[b]` is not saturated.
  - SAVE b: `calc_pend[b]`==0 and `save_pend[b]` is not saturated.
- Illegal opcode: the instruction is popped and dropped, `ins_err` is set, and nothing is issued.
- State machine:
  - IDLE: FIFO empty. Go to CHECK when the FIFO is non-empty.
  - CHECK: evaluate the head. If legal and hazard-free, pop it into the issue register and go to ISSUE. If illegal, pop it, set `ins_err`, and go back to CHECK (or IDLE if the FIFO is now empty). If blocked, stay in CHECK.
  - ISSUE: the selected `*_valid` is high and `unit_ins` holds the word. On the ready handshake, go to CHECK if the FIFO is non-empty, otherwise IDLE.
- Instructions issue strictly in order; a blocked head blocks everything behind it.

## Timing
- Reset values: all `*_valid` 0, `unit_ins` 0, `ins_err` 0, `working` 0, state IDLE, counters 0, FIFO empty. `ins_ready` is 1 once reset is released.
- `ins_ready` is registered and depends only on the FIFO being full. A simultaneous push and pop while full is not allowed; the host stalls.
- Latency: an instruction accepted at edge N into an empty FIFO with no hazard drives its `*_valid` high from edge N+2.
- Throughput: one issue every 2 cycles (one CHECK cycle plus one ISSUE cycle).
- Valid/data stability: once a `*_valid` is high, it and `unit_ins` stay stable until the ready handshake; the block never withdraws an issue.
- Counters update at the issue-handshake edge, so the next CHECK already sees the new count.
- `working` is registered, one cycle behind its sources.
- Reset mid-operation clears all state immediately; any in-flight issue is lost.

## Structure
- `ins_pkg` holds:
  - the opcode enum and the `OP_W`/`OP_LSB`/`BUF_BIT` constants;
  - the state enum `disp_state_t`;
  - `INS_W`=64.
- Sub-module `ins_fifo`: a synchronous FIFO with a registered full flag, a show-ahead head, and push/pop. Used only by this block.

## Test plan
- Single CONF pushed after reset -> `conf_valid` rises at edge 2 after acceptance, `unit_ins` matches the pushed word, `working` falls after the handshake.
- Push LOAD b0, then CALC b0 -> CALC is held until a `load_done[0]` pulse, then `calc_valid` rises 1 cycle after the pulse-cycle edge.
- Push 5 words with `load_ready`=0 and FIFO_DEPTH=4 -> the issue register plus FIFO absorb 5 words, `ins_ready` drops, and no word is lost once `load_ready` rises.
- Issue 7 LOADs to b1 with no done pulses -> the 8th stalls because the counter is saturated; one `load_done[1]` pulse releases it.
- Push opcode 4'hF followed by a SAVE b0 -> `ins_err`=1, the illegal word never appears on any `*_valid`, and the SAVE still issues.
- Assert `rst_n` low while `calc_valid` is high -> all outputs drop to their reset values within the same cycle, and `ins_ready`=1 after release.
